mem_req_bridge: RTL and testbench

Registered request/response bridge between the multicycle core's memory port (`mem_addr`/`mem_wdata`/`mem_wstrb`/`mem_rdata`, driven combinationally by the datapath) and the SoC's valid/ready memory bus. It captures one access per request and holds a stable payload on the bus until the bus accepts it. It returns read data and a one-cycle completion strobe to the control unit. An optional watchdog terminates accesses the bus never acknowledges and reports them as bus errors.

---
 rtl/mem_req_bridge_if.sv | 32 +++
 rtl/mem_req_bridge.sv | 107 ++++++++++
 tb/tb_mem_req_bridge.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_bridge_if.sv
// Signal bundle between the core memory port, the bridge and the SoC valid/ready bus.
// The bridge uses the master view; the core/bus environment uses the slave view.
interface mem_req_bridge_if;
  logic        core_valid;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [3:0]  core_wstrb;
  logic        core_ready;
  logic [31:0] core_rdata;
  logic        core_err;

  logic        bus_valid;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  modport master (
    input  core_valid, core_addr, core_wdata, core_wstrb,
    output core_ready, core_rdata, core_err,
    output bus_valid, bus_addr, bus_wdata, bus_wstrb,
    input  bus_ready, bus_rdata
  );

  modport slave (
    output core_valid, core_addr, core_wdata, core_wstrb,
    input  core_ready, core_rdata, core_err,
    input  bus_valid, bus_addr, bus_wdata, bus_wstrb,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/mem_req_bridge.sv
// Registered core-to-bus memory request bridge: one access per request, stable bus
// payload until accepted, one-cycle completion strobe, optional timeout watchdog.
module mem_req_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic             clk,
  input  logic             resetn,
  mem_req_bridge_if.master mem
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DONE
  } state_e;

  localparam bit          WDOG_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] CNT_LAST = WDOG_EN ? 16'(TIMEOUT_CYCLES - 1) : '0;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (mem.core_valid) begin
          addr_d  = mem.core_addr;
          wdata_d = mem.core_wdata;
          wstrb_d = mem.core_wstrb;
          cnt_d   = '0;
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        // A bus acknowledge wins over a watchdog expiry in the same cycle.
        if (mem.bus_ready) begin
          if (wstrb_q == '0) begin
            rdata_d = mem.bus_rdata;
          end
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (WDOG_EN) begin
          if (cnt_q == CNT_LAST) begin
            if (wstrb_q == '0) begin
              rdata_d = '1;
            end
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mem.bus_valid  = (state_q == ST_REQ);
  assign mem.bus_addr   = addr_q;
  assign mem.bus_wdata  = wdata_q;
  assign mem.bus_wstrb  = wstrb_q;
  assign mem.core_ready = (state_q == ST_DONE);
  assign mem.core_rdata = rdata_q;
  assign mem.core_err   = err_q;

endmodule

// File: tb/tb_mem_req_bridge.sv
// Directed bench for mem_req_bridge: three instances cover watchdog off, 8 and 4 cycles.
module tb_mem_req_bridge;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned pulses_a = 0;

  always #5 clk = ~clk;

  mem_req_bridge_if ifa ();
  mem_req_bridge_if ifb ();
  mem_req_bridge_if ifz ();

  mem_req_bridge #(.TIMEOUT_CYCLES(8)) u_a (.clk(clk), .resetn(resetn), .mem(ifa));
  mem_req_bridge #(.TIMEOUT_CYCLES(4)) u_b (.clk(clk), .resetn(resetn), .mem(ifb));
  mem_req_bridge #(.TIMEOUT_CYCLES(0)) u_z (.clk(clk), .resetn(resetn), .mem(ifz));

  always @(negedge clk) if (ifa.core_ready === 1'b1) pulses_a++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick();
    tick();
    vectors++;
    if ({ifa.bus_valid, ifa.core_ready, ifa.core_err, ifa.core_rdata, ifa.bus_addr,
         ifa.bus_wdata, ifa.bus_wstrb} !== 103'd0) begin
      miscompares++;
      $display("FAIL reset_a: got %h expected all zero", {ifa.bus_valid, ifa.core_ready,
               ifa.core_err, ifa.core_rdata, ifa.bus_addr, ifa.bus_wdata, ifa.bus_wstrb});
    end
    vectors++;
    if ({ifb.bus_valid, ifb.core_ready, ifb.core_err, ifz.bus_valid, ifz.core_ready,
         ifz.core_err} !== 6'd0) begin
      miscompares++;
      $display("FAIL reset_bz: got %b expected 000000", {ifb.bus_valid, ifb.core_ready,
               ifb.core_err, ifz.bus_valid, ifz.core_ready, ifz.core_err});
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_zero_wait_read();
    ifa.bus_ready  = 1'b1;
    ifa.bus_rdata  = 32'hDEAD_BEEF;
    ifa.core_addr  = 32'h1000_0004;
    ifa.core_wdata = 32'h0;
    ifa.core_wstrb = 4'b0000;
    ifa.core_valid = 1'b1;
    tick();
    vectors++;
    if ({ifa.bus_valid, ifa.core_ready, ifa.bus_addr, ifa.bus_wstrb} !== {2'b10, 32'h1000_0004, 4'h0}) begin
      miscompares++;
      $display("FAIL zw_req: got %h expected %h", {ifa.bus_valid, ifa.core_ready, ifa.bus_addr,
               ifa.bus_wstrb}, {2'b10, 32'h1000_0004, 4'h0});
    end
    tick();
    vectors++;
    if ({ifa.bus_valid, ifa.core_ready, ifa.core_err, ifa.core_rdata} !== {3'b010, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("FAIL zw_done: got %h expected %h", {ifa.bus_valid, ifa.core_ready, ifa.core_err,
               ifa.core_rdata}, {3'b010, 32'hDEAD_BEEF});
    end
    ifa.core_valid = 1'b0;
    tick();
    vectors++;
    if ({ifa.bus_valid, ifa.core_ready, ifa.core_rdata} !== {2'b00, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("FAIL zw_after: got %h expected %h", {ifa.bus_valid, ifa.core_ready, ifa.core_rdata},
               {2'b00, 32'hDEAD_BEEF});
    end
    ifa.bus_ready = 1'b0;
  endtask

  task automatic test_wait_state_write();
    ifa.bus_ready  = 1'b0;
    ifa.bus_rdata  = 32'h5555_AAAA;
    ifa.core_addr  = 32'h2000_0010;
    ifa.core_wdata = 32'h0000_A5A5;
    ifa.core_wstrb = 4'b0011;
    ifa.core_valid = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({ifa.bus_valid, ifa.core_ready, ifa.bus_addr, ifa.bus_wdata, ifa.bus_wstrb} !==
          {2'b10, 32'h2000_0010, 32'h0000_A5A5, 4'b0011}) begin
        miscompares++;
        $display("FAIL ws_hold[%0d]: got %h expected %h", i, {ifa.bus_valid, ifa.core_ready,
                 ifa.bus_addr, ifa.bus_wdata, ifa.bus_wstrb}, {2'b10, 32'h2000_0010, 32'h0000_A5A5, 4'b0011});
      end
      ifa.core_addr  = ~ifa.core_addr;
      ifa.core_wdata = ifa.core_wdata + 32'd1;
      ifa.core_wstrb = ~ifa.core_wstrb;
      if (i == 4) ifa.bus_ready = 1'b1;
      tick();
    end
    vectors++;
    if ({ifa.bus_valid, ifa.core_ready, ifa.core_err, ifa.core_rdata} !== {3'b010, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("FAIL ws_done: got %h expected %h", {ifa.bus_valid, ifa.core_ready, ifa.core_err,
               ifa.core_rdata}, {3'b010, 32'hDEAD_BEEF});
    end
    ifa.core_valid = 1'b0;
    ifa.bus_ready  = 1'b0;
    tick();
    vectors++;
    if (ifa.core_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ws_single_strobe: got %b expected 0", ifa.core_ready);
    end
  endtask

  task automatic test_timeout();
    // Write timeout: error reported, read data untouched.
    ifa.bus_ready  = 1'b0;
    ifa.core_addr  = 32'h2000_0020;
    ifa.core_wdata = 32'h1234_0000;
    ifa.core_wstrb = 4'b1111;
    ifa.core_valid = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if ({ifa.bus_valid, ifa.core_ready} !== 2'b10) begin
        miscompares++;
        $display("FAIL wto_valid[%0d]: got %b expected 10", i, {ifa.bus_valid, ifa.core_ready});
      end
      tick();
    end
    vectors++;
    if ({ifa.bus_valid, ifa.core_ready, ifa.core_err, ifa.core_rdata} !== {3'b011, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("FAIL wto_done: got %h expected %h", {ifa.bus_valid, ifa.core_ready, ifa.core_err,
               ifa.core_rdata}, {3'b011, 32'hDEAD_BEEF});
    end
    ifa.core_valid = 1'b0;
    tick();
    // Read timeout: bus_valid high exactly 8 cycles, all-ones data.
    ifa.core_addr  = 32'h3000_0000;
    ifa.core_wstrb = 4'b0000;
    ifa.core_valid = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if ({ifa.bus_valid, ifa.core_ready} !== 2'b10) begin
        miscompares++;
        $display("FAIL rto_valid[%0d]: got %b expected 10", i, {ifa.bus_valid, ifa.core_ready});
      end
      tick();
    end
    vectors++;
    if ({ifa.bus_valid, ifa.core_ready, ifa.core_err, ifa.core_rdata} !== {3'b011, 32'hFFFF_FFFF}) begin
      miscompares++;
      $display("FAIL rto_done: got %h expected %h", {ifa.bus_valid, ifa.core_ready, ifa.core_err,
               ifa.core_rdata}, {3'b011, 32'hFFFF_FFFF});
    end
    ifa.core_valid = 1'b0;
    tick();
    vectors++;
    if ({ifa.bus_valid, ifa.core_ready, ifa.core_err} !== 3'b001) begin
      miscompares++;
      $display("FAIL rto_err_hold: got %b expected 001", {ifa.bus_valid, ifa.core_ready, ifa.core_err});
    end
  endtask

  task automatic test_race_at_expiry();
    ifb.bus_ready  = 1'b0;
    ifb.bus_rdata  = 32'h1234_5678;
    ifb.core_addr  = 32'h5000_0000;
    ifb.core_wdata = 32'h0;
    ifb.core_wstrb = 4'b0000;
    ifb.core_valid = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) tick();
    vectors++;
    if ({ifb.core_ready, ifb.core_err, ifb.core_rdata} !== {2'b11, 32'hFFFF_FFFF}) begin
      miscompares++;
      $display("FAIL race_pre_to: got %h expected %h", {ifb.core_ready, ifb.core_err, ifb.core_rdata},
               {2'b11, 32'hFFFF_FFFF});
    end
    ifb.core_valid = 1'b0;
    tick();
    ifb.core_valid = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (ifb.bus_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL race_valid[%0d]: got %b expected 1", i, ifb.bus_valid);
      end
      if (i == 3) ifb.bus_ready = 1'b1;
      tick();
    end
    vectors++;
    if ({ifb.bus_valid, ifb.core_ready, ifb.core_err, ifb.core_rdata} !== {3'b010, 32'h1234_5678}) begin
      miscompares++;
      $display("FAIL race_done: got %h expected %h", {ifb.bus_valid, ifb.core_ready, ifb.core_err,
               ifb.core_rdata}, {3'b010, 32'h1234_5678});
    end
    ifb.core_valid = 1'b0;
    ifb.bus_ready  = 1'b0;
    tick();
  endtask

  task automatic test_no_watchdog();
    ifz.bus_ready  = 1'b0;
    ifz.bus_rdata  = 32'hA1B2_C3D4;
    ifz.core_addr  = 32'h6000_0000;
    ifz.core_wdata = 32'h0;
    ifz.core_wstrb = 4'b0000;
    ifz.core_valid = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if ({ifz.bus_valid, ifz.core_ready} !== 2'b10) begin
        miscompares++;
        $display("FAIL nowd_wait[%0d]: got %b expected 10", i, {ifz.bus_valid, ifz.core_ready});
      end
      if (i == 19) ifz.bus_ready = 1'b1;
      tick();
    end
    vectors++;
    if ({ifz.core_ready, ifz.core_err, ifz.core_rdata} !== {2'b10, 32'hA1B2_C3D4}) begin
      miscompares++;
      $display("FAIL nowd_done: got %h expected %h", {ifz.core_ready, ifz.core_err, ifz.core_rdata},
               {2'b10, 32'hA1B2_C3D4});
    end
    ifz.core_valid = 1'b0;
    ifz.bus_ready  = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_req();
    int unsigned base;
    ifa.bus_ready  = 1'b0;
    ifa.bus_rdata  = 32'h7777_7777;
    ifa.core_addr  = 32'h7000_0000;
    ifa.core_wstrb = 4'b0000;
    ifa.core_valid = 1'b1;
    tick();
    vectors++;
    if (ifa.bus_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_req_pre: got %b expected 1", ifa.bus_valid);
    end
    resetn = 1'b0;
    ifa.core_valid = 1'b0;
    tick();
    vectors++;
    if ({ifa.bus_valid, ifa.core_ready, ifa.core_err, ifa.core_rdata, ifa.bus_addr,
         ifa.bus_wdata, ifa.bus_wstrb} !== 103'd0) begin
      miscompares++;
      $display("FAIL rst_req_state: got %h expected all zero", {ifa.bus_valid, ifa.core_ready,
               ifa.core_err, ifa.core_rdata, ifa.bus_addr, ifa.bus_wdata, ifa.bus_wstrb});
    end
    resetn = 1'b1;
    base = pulses_a;
    tick();
    tick();
    vectors++;
    if ({ifa.bus_valid, 32'(pulses_a - base)} !== 33'd0) begin
      miscompares++;
      $display("FAIL rst_req_nostrobe: got valid=%b pulses=%0d expected 0/0", ifa.bus_valid, pulses_a - base);
    end
    ifa.bus_ready  = 1'b1;
    ifa.bus_rdata  = 32'h0BAD_F00D;
    ifa.core_addr  = 32'h7000_0008;
    ifa.core_valid = 1'b1;
    tick();
    vectors++;
    if ({ifa.bus_valid, ifa.bus_addr} !== {1'b1, 32'h7000_0008}) begin
      miscompares++;
      $display("FAIL rst_req_new_req: got %h expected %h", {ifa.bus_valid, ifa.bus_addr}, {1'b1, 32'h7000_0008});
    end
    tick();
    vectors++;
    if ({ifa.core_ready, ifa.core_err, ifa.core_rdata} !== {2'b10, 32'h0BAD_F00D}) begin
      miscompares++;
      $display("FAIL rst_req_new_done: got %h expected %h", {ifa.core_ready, ifa.core_err, ifa.core_rdata},
               {2'b10, 32'h0BAD_F00D});
    end
    ifa.core_valid = 1'b0;
    ifa.bus_ready  = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int unsigned base;
    base = pulses_a;
    ifa.bus_ready  = 1'b1;
    ifa.bus_rdata  = 32'hCAFE_F00D;
    ifa.core_addr  = 32'h8000_0000;
    ifa.core_wstrb = 4'b0000;
    ifa.core_valid = 1'b1;
    tick();
    vectors++;
    if (ifa.bus_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first_valid: got %b expected 1", ifa.bus_valid);
    end
    tick();
    vectors++;
    if ({ifa.core_ready, ifa.core_rdata} !== {1'b1, 32'hCAFE_F00D}) begin
      miscompares++;
      $display("FAIL b2b_first_done: got %h expected %h", {ifa.core_ready, ifa.core_rdata}, {1'b1, 32'hCAFE_F00D});
    end
    ifa.core_valid = 1'b0;
    tick();
    vectors++;
    if ({ifa.bus_valid, ifa.core_ready} !== 2'b00) begin
      miscompares++;
      $display("FAIL b2b_gap: got %b expected 00", {ifa.bus_valid, ifa.core_ready});
    end
    ifa.core_addr  = 32'h8000_0004;
    ifa.core_wdata = 32'h1122_3344;
    ifa.core_wstrb = 4'b1111;
    ifa.core_valid = 1'b1;
    tick();
    vectors++;
    if ({ifa.bus_valid, ifa.bus_addr, ifa.bus_wdata, ifa.bus_wstrb} !== {1'b1, 32'h8000_0004, 32'h1122_3344, 4'hF}) begin
      miscompares++;
      $display("FAIL b2b_second_req: got %h expected %h", {ifa.bus_valid, ifa.bus_addr, ifa.bus_wdata,
               ifa.bus_wstrb}, {1'b1, 32'h8000_0004, 32'h1122_3344, 4'hF});
    end
    tick();
    vectors++;
    if ({ifa.core_ready, ifa.core_err, ifa.core_rdata} !== {2'b10, 32'hCAFE_F00D}) begin
      miscompares++;
      $display("FAIL b2b_second_done: got %h expected %h", {ifa.core_ready, ifa.core_err, ifa.core_rdata},
               {2'b10, 32'hCAFE_F00D});
    end
    ifa.core_valid = 1'b0;
    ifa.bus_ready  = 1'b0;
    tick();
    tick();
    vectors++;
    if (pulses_a - base !== 2) begin
      miscompares++;
      $display("FAIL b2b_strobe_count: got %0d expected 2", pulses_a - base);
    end
  endtask

  initial begin
    ifa.core_valid = 1'b0; ifa.core_addr = '0; ifa.core_wdata = '0; ifa.core_wstrb = '0;
    ifa.bus_ready  = 1'b0; ifa.bus_rdata = '0;
    ifb.core_valid = 1'b0; ifb.core_addr = '0; ifb.core_wdata = '0; ifb.core_wstrb = '0;
    ifb.bus_ready  = 1'b0; ifb.bus_rdata = '0;
    ifz.core_valid = 1'b0; ifz.core_addr = '0; ifz.core_wdata = '0; ifz.core_wstrb = '0;
    ifz.bus_ready  = 1'b0; ifz.bus_rdata = '0;

    test_reset();
    test_zero_wait_read();
    test_wait_state_write();
    test_timeout();
    test_race_at_expiry();
    test_no_watchdog();
    test_reset_in_req();
    test_back_to_back();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
